// File: rtl/dvp_cam_tx.sv
// DVP camera-port transmitter: serialises RGB565 pixels as high/low byte pairs
// with PIXCLK/VSYNC/HREF framing, emulating an OV2640-style sensor output.
module dvp_cam_tx #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned H_BLANK  = 320,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned VS_LINES = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_FRONT  = 10,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_en,
  input  logic [15:0] I_pix_data,
  input  logic        I_pix_valid,
  output logic        O_pix_ready,
  output logic        O_pclk,
  output logic        O_vsync,
  output logic        O_href,
  output logic [9:0]  O_pixdata,
  output logic        O_sof,
  output logic        O_underrun,
  output logic [15:0] O_underrun_cnt
);

  localparam int unsigned LINE_BYTES  = 2 * H_ACT + H_BLANK;
  localparam int unsigned FRAME_LINES = VS_LINES + V_BACK + V_ACT + V_FRONT;
  localparam int BW = $clog2(LINE_BYTES + 1);
  localparam int LW = $clog2(FRAME_LINES + 1);

  localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - 1);
  localparam logic [BW-1:0] ACT_BYTES = BW'(2 * H_ACT);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
  localparam logic [LW-1:0] VB_START  = LW'(VS_LINES);
  localparam logic [LW-1:0] ACT_START = LW'(VS_LINES + V_BACK);
  localparam logic [LW-1:0] VF_START  = LW'(VS_LINES + V_BACK + V_ACT);

  // state     | meaning
  // ST_IDLE   | stopped, PCLK low, waiting for I_en
  // ST_VSYNC  | VSYNC asserted lines at frame start
  // ST_VBACK  | blank lines before the first active line
  // ST_ACTIVE | lines carrying pixel bytes with HREF
  // ST_VFRONT | blank lines after the last active line
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  logic          pclk_q, pclk_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    pixdata_q, pixdata_d;
  logic          sof_q, sof_d;
  logic          und_q, und_d;
  logic [15:0]   und_cnt_q, und_cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic [7:0]    lat_q, lat_d;
  logic          ready_q, ready_d;

  logic          frame_end;
  logic          at_boundary;
  logic          go;
  logic [BW-1:0] byte_nxt;
  logic [LW-1:0] line_nxt;
  logic [2:0]    state_nxt;
  logic          href_nxt;

  // Position of the byte period that starts at the next phase-0 edge.
  always_comb begin
    frame_end   = (state_q != ST_IDLE) && (byte_q == BYTE_LAST) && (line_q == LINE_LAST);
    at_boundary = (state_q == ST_IDLE) || frame_end;
    go          = (state_q != ST_IDLE) || I_en;
    byte_nxt    = '0;
    line_nxt    = '0;
    if (!at_boundary) begin
      if (byte_q == BYTE_LAST) begin
        line_nxt = line_q + 1'b1;
      end else begin
        byte_nxt = byte_q + 1'b1;
        line_nxt = line_q;
      end
    end
    if (at_boundary && !I_en) begin
      state_nxt = ST_IDLE;
    end else if (line_nxt < VB_START) begin
      state_nxt = ST_VSYNC;
    end else if (line_nxt < ACT_START) begin
      state_nxt = ST_VBACK;
    end else if (line_nxt < VF_START) begin
      state_nxt = ST_ACTIVE;
    end else begin
      state_nxt = ST_VFRONT;
    end
    href_nxt = (state_nxt == ST_ACTIVE) && (byte_nxt < ACT_BYTES);
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    byte_d    = byte_q;
    line_d    = line_q;
    pclk_d    = pclk_q;
    vsync_d   = vsync_q;
    href_d    = href_q;
    pixdata_d = pixdata_q;
    sof_d     = 1'b0;
    und_d     = 1'b0;
    und_cnt_d = und_cnt_q;
    hold_d    = hold_q;
    lat_d     = lat_q;
    ready_d   = ready_q;

    if (I_pix_valid && ready_q) begin
      hold_d  = I_pix_data;
      ready_d = 1'b0;
    end

    if (phase_q) begin
      phase_d = 1'b0;
      pclk_d  = 1'b1;
    end else if (go) begin
      phase_d   = (state_nxt != ST_IDLE);
      pclk_d    = 1'b0;
      state_d   = state_nxt;
      byte_d    = byte_nxt;
      line_d    = line_nxt;
      sof_d     = at_boundary && I_en;
      vsync_d   = (state_nxt == ST_VSYNC) ? VS_POL : ~VS_POL;
      href_d    = href_nxt;
      pixdata_d = 8'h00;
      if (href_nxt) begin
        if (!byte_nxt[0]) begin
          // A full register can never also be loaded on this edge, so the consume is exclusive.
          if (!ready_q) begin
            pixdata_d = hold_q[15:8];
            lat_d     = hold_q[7:0];
            ready_d   = 1'b1;
          end else begin
            lat_d = 8'h00;
            und_d = 1'b1;
            if (und_cnt_q != 16'hFFFF) begin
              und_cnt_d = und_cnt_q + 16'd1;
            end
          end
        end else begin
          pixdata_d = lat_q;
        end
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      byte_q    <= '0;
      line_q    <= '0;
      pclk_q    <= 1'b0;
      vsync_q   <= ~VS_POL;
      href_q    <= 1'b0;
      pixdata_q <= 8'h00;
      sof_q     <= 1'b0;
      und_q     <= 1'b0;
      und_cnt_q <= 16'h0000;
      hold_q    <= 16'h0000;
      lat_q     <= 8'h00;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      byte_q    <= byte_d;
      line_q    <= line_d;
      pclk_q    <= pclk_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      pixdata_q <= pixdata_d;
      sof_q     <= sof_d;
      und_q     <= und_d;
      und_cnt_q <= und_cnt_d;
      hold_q    <= hold_d;
      lat_q     <= lat_d;
      ready_q   <= ready_d;
    end
  end

  assign O_pix_ready    = ready_q;
  assign O_pclk         = pclk_q;
  assign O_vsync        = vsync_q;
  assign O_href         = href_q;
  assign O_pixdata      = {pixdata_q, 2'b00};
  assign O_sof          = sof_q;
  assign O_underrun     = und_q;
  assign O_underrun_cnt = und_cnt_q;

endmodule
